// File: rtl/bus_responder_if.sv
// Bus bundle between the 8008 core, the responder and the memory/IO side.
// Parameters must match the responder instance they connect to.
interface bus_responder_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 14
);
    logic [2:0]            state;
    logic [WIDTH-1:0]      D_out;
    logic [WIDTH-1:0]      D_in;
    logic                  Ready;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ack;
    logic [4:0]            io_port;
    logic                  io_wr;
    logic [WIDTH-1:0]      io_wdata;
    logic [WIDTH-1:0]      io_rdata;

    modport master (
        output state, D_out, mem_rdata, mem_ack, io_rdata,
        input  D_in, Ready, mem_req, mem_we, mem_addr,
        input  mem_wdata, io_port, io_wr, io_wdata
    );

    modport slave (
        input  state, D_out, mem_rdata, mem_ack, io_rdata,
        output D_in, Ready, mem_req, mem_we, mem_addr,
        output mem_wdata, io_port, io_wr, io_wdata
    );
endinterface

// File: rtl/bus_responder.sv
// External-side responder for the 8008 multiplexed bus: decodes T1/T2,
// runs memory/IO accesses, posts writes and jams the interrupt opcode.
module bus_responder #(
    parameter int               WIDTH      = 8,
    parameter int               ADDR_WIDTH = 14,
    parameter logic [WIDTH-1:0] INTR_INSTR = 8'h05
) (
    input logic clk,
    input logic rst,
    bus_responder_if.slave bus
);
    localparam logic [2:0] S_T2  = 3'b001;
    localparam logic [2:0] S_T1  = 3'b010;
    localparam logic [2:0] S_T1I = 3'b011;
    localparam logic [2:0] S_T3  = 3'b100;

    localparam logic [1:0] C_PCI = 2'b00;
    localparam logic [1:0] C_PCC = 2'b10;
    localparam logic [1:0] C_PCW = 2'b11;

    typedef enum logic [2:0] {
        IDLE, ADDR, DRAIN, RD_REQ, RDY, WR_CAP
    } fsm_t;

    fsm_t fsm_q, fsm_n;

    logic [WIDTH-1:0]      addr_lo_q, addr_lo_n;
    logic [5:0]            addr_hi_q, addr_hi_n;
    logic [1:0]            cyc_q, cyc_n;
    logic [WIDTH-1:0]      data_q, data_n;
    logic                  wr_pend_q, wr_pend_n;
    logic                  intr_q, intr_n;
    logic                  ready_q, ready_n;
    logic                  req_q, req_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [WIDTH-1:0]      wdata_q, wdata_n;
    logic [4:0]            port_q, port_n;
    logic                  iowr_q, iowr_n;
    logic [WIDTH-1:0]      iodat_q, iodat_n;

    logic       t1, t2, t3, ack, io_out_q;
    logic [1:0] cyc_in;

    assign t1     = (bus.state == S_T1) || (bus.state == S_T1I);
    assign t2     = bus.state == S_T2;
    assign t3     = bus.state == S_T3;
    assign ack    = req_q && bus.mem_ack;
    assign cyc_in = bus.D_out[7:6];

    assign io_out_q = addr_hi_q[5:4] != 2'b00;

    always_comb begin
        fsm_n     = fsm_q;
        addr_lo_n = addr_lo_q;
        addr_hi_n = addr_hi_q;
        cyc_n     = cyc_q;
        data_n    = data_q;
        wr_pend_n = wr_pend_q;
        intr_n    = intr_q;
        ready_n   = ready_q;
        req_n     = req_q;
        we_n      = we_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        port_n    = port_q;
        iowr_n    = 1'b0;
        iodat_n   = iodat_q;

        if (t2) begin
            addr_hi_n = bus.D_out[5:0];
            cyc_n     = cyc_in;
        end

        // Any ack retires the outstanding request, posted write or orphan read.
        if (ack) begin
            req_n = 1'b0;
            if (we_q) wr_pend_n = 1'b0;
        end

        unique case (fsm_q)
            IDLE: ;
            ADDR: if (t2) begin
                unique case (1'b1)
                    (cyc_in == C_PCI) && intr_q: begin
                        data_n  = INTR_INSTR;
                        ready_n = 1'b1;
                        fsm_n   = RDY;
                    end
                    cyc_in == C_PCC: begin
                        port_n = bus.D_out[5:1];
                        if (bus.D_out[5:4] != 2'b00) begin
                            iowr_n  = 1'b1;
                            iodat_n = addr_lo_q;
                        end else begin
                            data_n = bus.io_rdata;
                        end
                        ready_n = 1'b1;
                        fsm_n   = RDY;
                    end
                    cyc_in == C_PCW: begin
                        ready_n = !req_q;
                        fsm_n   = req_q ? DRAIN : WR_CAP;
                    end
                    default: begin
                        if (req_q) begin
                            fsm_n = DRAIN;
                        end else begin
                            req_n  = 1'b1;
                            we_n   = 1'b0;
                            addr_n = {bus.D_out[5:0], addr_lo_q};
                            fsm_n  = RD_REQ;
                        end
                    end
                endcase
            end
            DRAIN: begin
                if (cyc_q == C_PCW) begin
                    if (!req_q || ack) begin
                        ready_n = 1'b1;
                        fsm_n   = WR_CAP;
                    end
                end else if (!req_q) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = {addr_hi_q, addr_lo_q};
                    fsm_n  = RD_REQ;
                end
            end
            RD_REQ: if (ack) begin
                data_n  = bus.mem_rdata;
                ready_n = 1'b1;
                fsm_n   = RDY;
            end
            RDY: if (t3) fsm_n = IDLE;
            WR_CAP: if (t3) begin
                wdata_n   = bus.D_out;
                addr_n    = {addr_hi_q, addr_lo_q};
                we_n      = 1'b1;
                req_n     = 1'b1;
                wr_pend_n = 1'b1;
                fsm_n     = IDLE;
            end
            default: fsm_n = IDLE;
        endcase

        // A T1 anywhere starts a new cycle; a live read keeps going unseen.
        if (t1) begin
            addr_lo_n = bus.D_out;
            ready_n   = 1'b0;
            intr_n    = bus.state == S_T1I;
            fsm_n     = ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            cyc_q     <= '0;
            data_q    <= '0;
            wr_pend_q <= 1'b0;
            intr_q    <= 1'b0;
            ready_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            port_q    <= '0;
            iowr_q    <= 1'b0;
            iodat_q   <= '0;
        end else begin
            fsm_q     <= fsm_n;
            addr_lo_q <= addr_lo_n;
            addr_hi_q <= addr_hi_n;
            cyc_q     <= cyc_n;
            data_q    <= data_n;
            wr_pend_q <= wr_pend_n;
            intr_q    <= intr_n;
            ready_q   <= ready_n;
            req_q     <= req_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            port_q    <= port_n;
            iowr_q    <= iowr_n;
            iodat_q   <= iodat_n;
        end
    end

    assign bus.D_in = (t3 && (cyc_q != C_PCW) && !((cyc_q == C_PCC) && io_out_q))
                    ? data_q : '0;

    assign bus.Ready     = ready_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.io_port   = port_q;
    assign bus.io_wr     = iowr_q;
    assign bus.io_wdata  = iodat_q;
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- External-side responder for the 8008 core's multiplexed bus.
- Tracks the core's `state` output, captures the low address in T1/T1I and the high address plus cycle type in T2, then holds Ready low until the backing memory or I/O completes.
- Returns read data on D_in during T3, and captures write data from D_out during T3.
- Sits between 8008_core and the memory/IO subsystem. It also jams the interrupt instruction on an interrupt-acknowledge fetch.

Parameters:
- WIDTH, 8, data bus width.
- ADDR_WIDTH, 14, memory address width (low byte plus 6 high bits).
- INTR_INSTR, 8'h05, byte returned on the PCI cycle that follows T1I (RST 0).

Ports:
- clk  input  1  single system clock; all state advances on its rising edge; same clock as the core FSM.
- rst  input  1  asynchronous, active-high reset.
- state  input  3  core state_t: WAIT=000, T2=001, T1=010, T1I=011, T3=100, T5=101, STOPPED=110, T4=111.
- D_out  input  WIDTH  core output bus (address in T1/T2, write data in T3).
- D_in  output  WIDTH  data to core; valid during T3.
- Ready  output  1  registered; low holds the core in WAIT.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  output  ADDR_WIDTH  stable while mem_req.
- mem_wdata  output  WIDTH  stable while mem_req and mem_we.
- mem_rdata  input  WIDTH  sampled on the mem_ack cycle.
- mem_ack  input  1  one-cycle completion pulse; ignored unless mem_req is high.
- io_port  output  5  port number of the last PCC cycle (addr_hi[5:1]).
- io_wr  output  1  one-cycle strobe for an output-port write.
- io_wdata  output  WIDTH  output-port data (the T1 byte of the PCC cycle).
- io_rdata  input  WIDTH  input-port data, sampled at the T2 edge of the PCC cycle.

Behaviour:
- Reset: Ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, io_wr=0, io_port=0, io_wdata=0. Internal registers are also cleared:
  - data_reg=0 (the byte later driven onto D_in);
  - wr_pending=0 (a captured write not yet acknowledged);
  - intr_flag=0 (set by T1I).
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and any pending write is discarded.
- D_in is combinational: data_reg when state==T3 and the cycle is PCI, PCR or PCC-input; otherwise 0.
- The bus state is sampled every rising edge. The core samples Ready in T2/WAIT, so every bus cycle has at least one WAIT state by design.
- T1 or T1I edge:
  - addr_lo <= D_out; Ready <= 0;
  - intr_flag <= (state==T1I).
- T2 edge: addr_hi <= D_out[5:0]; cyc <= D_out[7:6], where 00=PCI, 01=PCR, 10=PCC, 11=PCW.
- FSM states: IDLE, ADDR (T1 seen), DRAIN (waiting on a pending write), RD_REQ, RDY, WR_CAP.
  - IDLE: on T1/T1I go to ADDR.
  - ADDR on T2 edge, PCI with intr_flag: data_reg <= INTR_INSTR; Ready <= 1; go to RDY. No memory access.
  - ADDR on T2 edge, PCI/PCR otherwise:
    - wr_pending=1: go to DRAIN (write completes first; ordering is preserved).
    - else: mem_req <= 1, mem_we <= 0, mem_addr <= {addr_hi, addr_lo}; go to RD_REQ.
  - ADDR on T2 edge, PCC:
    - io_port <= D_out[5:1].
    - If D_out[5:4] != 0 (output port): io_wr pulses for one cycle with io_wdata=addr_lo.
    - If input port: data_reg <= io_rdata.
    - Ready <= 1; go to RDY.
  - ADDR on T2 edge, PCW: Ready <= !wr_pending.
    - wr_pending=0: go to WR_CAP.
    - wr_pending=1: go to DRAIN; Ready <= 1 follows the write ack.
  - DRAIN: on the write ack, clear wr_pending, then issue the deferred read the next cycle (or go to WR_CAP with Ready=1 for PCW).
  - RD_REQ: on mem_ack, data_reg <= mem_rdata; mem_req <= 0; Ready <= 1; go to RDY.
  - RDY: on T3 edge go to IDLE.
  - WR_CAP: on T3 edge:
    - mem_wdata <= D_out, mem_addr <= {addr_hi, addr_lo};
    - mem_we <= 1, mem_req <= 1, wr_pending <= 1 (write is posted);
    - go to IDLE.
- Posted-write ack while idle: mem_req <= 0, wr_pending <= 0.
- mem_ack on the same cycle mem_req rises is legal. mem_ack with mem_req low is ignored.
- STOPPED, T4, T5: no action; any posted write keeps draining.
- An unexpected T1 in a non-IDLE state (protocol violation) restarts at ADDR. An outstanding read request is held until its ack, and its data is discarded.

Test Plan:
- Fetch: T1 D_out=8'h34, T2 D_out=8'h12 (PCI), mem_ack after 3 cycles with mem_rdata=8'hC7 -> mem_addr=14'h1234, mem_we=0; Ready high only after ack; D_in=8'hC7 in T3.
- Write: T1 8'h00, T2 8'hC1 (PCW), T3 D_out=8'h5A -> Ready high one cycle after T2 edge; then mem_req=1, mem_we=1, mem_addr=14'h0100, mem_wdata=8'h5A.
- Write then read with ack delayed 5 cycles: PCW then PCR of 14'h0100 -> read mem_req is not raised until the write ack; Ready stays low meanwhile; D_in=8'h5A when memory echoes it.
- Interrupt: state T1I then PCI -> no mem_req; D_in=8'h05 in T3; the next normal T1 clears intr_flag.
- I/O:
  - PCC output port 5'h11 with T1 byte 8'hA5 -> one-cycle io_wr, io_port=5'h11, io_wdata=8'hA5.
  - PCC input port 5'h02 with io_rdata=8'h3C -> D_in=8'h3C in T3.
- Reset while RD_REQ -> mem_req and Ready drop the same cycle; after release, a fresh fetch works normally.
